// File: rtl/oric_mem_pkg.sv
// Shared types and constants for the Oric SDRAM port arbiter.
package oric_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_FDC = 1'b1
  } owner_t;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_BOTH = 2'b11;

  // Byte strobes: writes touch only the addressed lane, reads fetch the whole word.
  function automatic logic [1:0] ds_for(input logic we, input logic a0);
    if (we) return a0 ? DS_HI : DS_LO;
    return DS_BOTH;
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Grant select between CPU (A) and FDC (B) with a starvation counter
// that forces a B grant after STARVE_MAX consecutive contended A grants.
module arb_priority_sel #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
  input  logic a_req,
  input  logic b_req,
  output logic grant_a,
  output logic grant_b
);

  localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  // Combinational grant: A wins contention unless B has waited long enough.
  always_comb begin
    grant_b = b_req & (~a_req | starved);
    grant_a = a_req & ~grant_b;
  end

  // Starvation counter: counts A grants taken while B was pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (grant_b) begin
        starve_cnt <= '0;
      end else if (grant_a) begin
        if (!b_req)       starve_cnt <= '0;
        else if (!starved) starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter in front of a toggle-handshake SDRAM port.
// Port A = Oric CPU bus, port B = FDC sector buffer. Byte-wide requesters
// are steered onto the 16-bit memory port. Optional WAIT timeout is built
// when the macro ARB_TIMEOUT_EN is defined.
module sdram_port_arbiter
  import oric_mem_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_d,
  output logic [7:0]        a_q,
  output logic              a_done,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_d,
  output logic [7:0]        b_q,
  output logic              b_done,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_a,
  output logic [1:0]        mem_ds,
  output logic              mem_we,
  output logic [15:0]       mem_d,
  input  logic [15:0]       mem_q,
  output logic              busy,
  output logic              timeout_err
);

  if (STARVE_MAX < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("sdram_port_arbiter: STARVE_MAX and TIMEOUT must be >= 1");
  end

  arb_state_t state, state_nxt;
  owner_t     owner;

  logic       grant_en, grant_a, grant_b, grant;
  logic       ack_eff, ack_hit, tmo, finish;
  logic [7:0] rd_byte, cap_byte;

  assign grant_en = (state == IDLE);
  assign grant    = grant_en & (grant_a | grant_b);

  arb_priority_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sel (
    .clk     (clk_sys),
    .reset   (reset),
    .grant_en(grant_en),
    .a_req   (a_req),
    .b_req   (b_req),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TMO_W-1:0] wait_cnt;
  logic             ack_shadow;
  logic             tmo_err;

  // The shadow re-aligns a lost acknowledge so later handshakes still pair up.
  assign ack_eff     = mem_ack ^ ack_shadow;
  assign tmo         = (state == WAIT) && (ack_eff != mem_req) &&
                       (wait_cnt == TMO_W'(TIMEOUT - 1));
  assign timeout_err = tmo_err;

  // WAIT-cycle counter, ack shadow and sticky timeout flag.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wait_cnt   <= '0;
      ack_shadow <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (tmo) begin
        ack_shadow <= mem_ack ^ mem_req;
        tmo_err    <= 1'b1;
      end
    end
  end
`else
  assign ack_eff     = mem_ack;
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign ack_hit  = (ack_eff == mem_req);
  assign finish   = (state == WAIT) && (ack_hit || tmo);
  assign rd_byte  = mem_a[0] ? mem_q[15:8] : mem_q[7:0];
  assign cap_byte = tmo ? 8'hFF : rd_byte;

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: one access at a time, IDLE -> ISSUE -> WAIT -> DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_a || grant_b) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (ack_hit || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: busy and the owner's one-cycle done pulse.
  always_comb begin
    busy   = (state != IDLE);
    a_done = (state == DONE) && (owner == OWN_CPU);
    b_done = (state == DONE) && (owner == OWN_FDC);
  end

  // Request latch on grant, toggle in ISSUE, read-byte capture on completion.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      owner   <= OWN_CPU;
      mem_req <= 1'b0;
      mem_a   <= '0;
      mem_ds  <= 2'b00;
      mem_we  <= 1'b0;
      mem_d   <= 16'h0000;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
    end else begin
      if (grant) begin
        if (grant_b) begin
          owner  <= OWN_FDC;
          mem_a  <= b_addr;
          mem_we <= b_we;
          mem_d  <= {b_d, b_d};
          mem_ds <= ds_for(b_we, b_addr[0]);
        end else begin
          owner  <= OWN_CPU;
          mem_a  <= a_addr;
          mem_we <= a_we;
          mem_d  <= {a_d, a_d};
          mem_ds <= ds_for(a_we, a_addr[0]);
        end
      end
      if (state == ISSUE) mem_req <= ~mem_req;
      if (finish && (tmo || !mem_we)) begin
        if (owner == OWN_CPU) a_q <= cap_byte;
        else                  b_q <= cap_byte;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: drivers push expected completions,
// a monitor pops and compares whenever a done pulse appears.
module tb_sdram_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [23:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_d = '0, b_d = '0;
  logic [7:0]  a_q, b_q;
  logic        a_done, b_done;
  logic        mem_req, mem_ack, mem_we, busy, timeout_err;
  logic [23:0] mem_a;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d;
  logic [15:0] mem_q = '0;

  sdram_port_arbiter #(.ADDR_W(24), .STARVE_MAX(4), .TIMEOUT(255)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_d(a_d), .a_q(a_q), .a_done(a_done),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_d(b_d), .b_q(b_q), .b_done(b_done),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_ds(mem_ds),
    .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit          port;
    bit          we;
    logic [23:0] addr;
    logic [1:0]  ds;
    logic [15:0] d;
    logic [7:0]  q;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mem_en  = 1;
  int   mem_lat = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SDRAM model: answers each observed request toggle after mem_lat cycles.
  initial begin
    int pend;
    logic last;
    mem_ack = 0; last = 0; pend = 0;
    forever begin
      @(posedge clk_sys); #1;
      if (reset) begin
        mem_ack = 0; last = 0; pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) mem_ack = ~mem_ack;
        end
        if (mem_req != last) begin
          last = mem_req;
          if (mem_en) pend = mem_lat;
        end
      end
    end
  end

  // Monitor: pop one expectation per done pulse and compare.
  initial begin
    exp_t e;
    bit   prev_done = 0;
    forever begin
      @(negedge clk_sys);
      if (a_done || b_done) begin
        chk("done_one_cycle", {31'd0, prev_done}, 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'd0, b_done}, 32'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("done_port", {31'd0, b_done}, {31'd0, e.port});
          chk("both_done", {31'd0, a_done & b_done}, 0);
          chk("q", e.port ? b_q : a_q, e.q);
          chk("mem_a", mem_a, e.addr);
          chk("mem_ds", mem_ds, e.ds);
          chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
          chk("mem_d", mem_d, e.d);
        end
      end
      prev_done = a_done | b_done;
    end
  end

  task automatic push(input bit port, input bit we, input logic [23:0] addr,
                      input logic [1:0] ds, input logic [15:0] d, input logic [7:0] q);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.ds = ds; e.d = d; e.q = q;
    sb.push_back(e);
  endtask

  // One access on one port; expected steering and q are given by hand.
  task automatic access(input bit port, input bit we, input logic [23:0] addr,
                        input logic [7:0] d, input logic [15:0] mq,
                        input logic [1:0] ds_exp, input logic [7:0] q_exp,
                        input int budget);
    bit got = 0;
    int n = 0;
    mem_q = mq;
    push(port, we, addr, ds_exp, {d, d}, q_exp);
    if (port) begin b_we = we; b_addr = addr; b_d = d; b_req = 1; end
    else      begin a_we = we; a_addr = addr; a_d = d; a_req = 1; end
    while (!got && n < budget) begin
      @(negedge clk_sys); n++;
      if (port ? b_done : a_done) got = 1;
    end
    a_req = 0; b_req = 0;
    chk("done_seen", {31'd0, got}, 1);
  endtask

  initial begin
    logic req0;
    int   n;
    bit   got;

    // Reset state
    repeat (2) @(negedge clk_sys);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_done", {30'd0, a_done, b_done}, 0);
    chk("rst_q", {16'd0, a_q, b_q}, 0);
    chk("rst_mem_ds", {30'd0, mem_ds}, 0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 0);
    reset = 0;
    @(negedge clk_sys);

    // CPU read with grant-to-toggle latency check
    req0 = mem_req;
    mem_q = 16'hAB12;
    push(0, 0, 24'h000123, 2'b11, 16'h0000, 8'hAB);
    a_we = 0; a_addr = 24'h000123; a_d = 8'h00; a_req = 1;
    @(negedge clk_sys);
    chk("grant_busy", {31'd0, busy}, 1);
    chk("no_toggle_at_grant", {31'd0, mem_req}, {31'd0, req0});
    @(negedge clk_sys);
    chk("toggle_after_grant", {31'd0, mem_req}, {31'd0, ~req0});
    got = 0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk_sys); n++;
      if (a_done) got = 1;
    end
    a_req = 0;
    chk("done_seen", {31'd0, got}, 1);

    access(0, 1, 24'h000400, 8'h5A, 16'h0000, 2'b01, 8'hAB, 50); // CPU write even
    access(0, 1, 24'h000401, 8'hE1, 16'h0000, 2'b10, 8'hAB, 50); // CPU write odd
    access(1, 0, 24'h000801, 8'h00, 16'h77C4, 2'b11, 8'h77, 50); // FDC read odd
    access(1, 1, 24'h000803, 8'h3C, 16'h0000, 2'b10, 8'h77, 50); // FDC write odd
    access(0, 0, 24'hFFFFFF, 8'h00, 16'hBEEF, 2'b11, 8'hBE, 50); // top address

    // Continuous contention: A,A,A,A,B,A,A,A,A,B
    mem_q = 16'h1234;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push(1, 0, 24'h000021, 2'b11, 16'h0000, 8'h12);
      else                  push(0, 0, 24'h000010, 2'b11, 16'h0000, 8'h34);
    end
    a_we = 0; a_addr = 24'h000010; a_d = 0;
    b_we = 0; b_addr = 24'h000021; b_d = 0;
    a_req = 1; b_req = 1;
    n = 0;
    for (int c = 0; c < 400 && n < 10; c++) begin
      @(negedge clk_sys);
      if (a_done || b_done) n++;
    end
    a_req = 0; b_req = 0;
    chk("starve_dones", n, 10);

    // Reset during WAIT: no done, async clear, then a normal access
    @(negedge clk_sys);
    mem_en = 0;
    a_we = 0; a_addr = 24'h000050; a_req = 1;
    repeat (4) @(negedge clk_sys);
    #2 reset = 1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_mem_req", {31'd0, mem_req}, 0);
    chk("mid_rst_done", {30'd0, a_done, b_done}, 0);
    a_req = 0;
    repeat (2) @(negedge clk_sys);
    reset = 0;
    mem_en = 1;
    @(negedge clk_sys);
    access(0, 0, 24'h000002, 8'h00, 16'h9911, 2'b11, 8'h11, 50);

    // FDC drops b_req during WAIT: one done, no second access
    mem_lat = 5;
    mem_q = 16'h5566;
    push(1, 0, 24'h0000FE, 2'b11, 16'h0000, 8'h66);
    b_we = 0; b_addr = 24'h0000FE; b_d = 0; b_req = 1;
    repeat (2) @(negedge clk_sys);
    b_req = 0;
    got = 0; n = 0;
    while (!got && n < 50) begin
      @(negedge clk_sys); n++;
      if (b_done) got = 1;
    end
    chk("drop_done_seen", {31'd0, got}, 1);
    repeat (6) @(negedge clk_sys);
    chk("drop_no_reissue", {31'd0, busy}, 0);
    mem_lat = 2;

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: done after 255 WAIT cycles with q=FF
    mem_en = 0;
    req0 = mem_req;
    push(0, 0, 24'h000030, 2'b11, 16'h0000, 8'hFF);
    a_we = 0; a_addr = 24'h000030; a_d = 0; a_req = 1;
    n = 0;
    while (mem_req == req0 && n < 10) begin @(negedge clk_sys); n++; end
    got = 0; n = 0;
    while (!got && n < 400) begin
      n++;
      if (a_done) got = 1;
      else @(negedge clk_sys);
    end
    a_req = 0;
    chk("tmo_done_seen", {31'd0, got}, 1);
    chk("tmo_latency", n, 256);
    chk("tmo_err_set", {31'd0, timeout_err}, 1);
    mem_en = 1;
    @(negedge clk_sys);
    access(0, 0, 24'h000031, 8'h00, 16'hC3A5, 2'b11, 8'hC3, 50);
    chk("tmo_err_sticky", {31'd0, timeout_err}, 1);
`endif

    repeat (4) @(negedge clk_sys);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
